// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state encoding and timeout default
// for the two-requester ALU arbiter.
package alu_pkg;

    localparam int TIMEOUT_DEF = 64;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_ILL = 3'd3;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        RESP
    } state_t;

    function automatic logic is_illegal(input logic [2:0] op);
        return op == OP_ILL;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Bus between the arbiter (master) and the shared ALU (slave):
// cs/op/a/b toward the ALU, out/cout/rdy back from it.
interface alu_arbiter_if;

    logic        alu_cs;
    logic [2:0]  alu_op;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_out;
    logic        alu_cout;
    logic        alu_rdy;

    modport master (
        output alu_cs, alu_op, alu_a, alu_b,
        input  alu_out, alu_cout, alu_rdy
    );

    modport slave (
        input  alu_cs, alu_op, alu_a, alu_b,
        output alu_out, alu_cout, alu_rdy
    );

endinterface

// File: rtl/arb_rr2.sv
// Two-way round-robin grant (combinational).
// in: req0, req1, last (last granted index); out: vld, gnt (index).
module arb_rr2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic vld,
    output logic gnt
);

    assign vld = req0 | req1;
    // On a tie the requester not served last wins.
    assign gnt = (req0 && req1) ? ~last : req1;

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one shared ALU with timeout abort.
// Ports: clk, rst_n, req/op/a/b per requester, done/res/cout per requester, busy, err, alu bus.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic [2:0]    op0,
    input  logic [2:0]    op1,
    input  logic [15:0]   a0,
    input  logic [15:0]   b0,
    input  logic [15:0]   a1,
    input  logic [15:0]   b1,
    output logic          done0,
    output logic          done1,
    output logic [15:0]   res0,
    output logic [15:0]   res1,
    output logic          cout0,
    output logic          cout1,
    output logic          busy,
    output logic          err,
    alu_arbiter_if.master alu
);

    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    state_t        state;
    state_t        state_nx;
    logic          gnt_q;
    logic          last_q;
    logic          armed_q;
    logic [2:0]    op_q;
    logic [15:0]   a_q;
    logic [15:0]   b_q;
    logic [CW-1:0] cnt_q;

    logic          arb_vld;
    logic          arb_gnt;
    logic [2:0]    sel_op;
    logic [15:0]   sel_a;
    logic [15:0]   sel_b;
    logic          active;
    logic          tmo;
    logic          grant;
    logic          bad_op;
    logic          wr_res;
    logic          tgt;
    logic [15:0]   res_nx;
    logic          cout_nx;

    arb_rr2 u_arb (
        .req0 (req0),
        .req1 (req1),
        .last (last_q),
        .vld  (arb_vld),
        .gnt  (arb_gnt)
    );

    assign sel_op = arb_gnt ? op1 : op0;
    assign sel_a  = arb_gnt ? a1 : a0;
    assign sel_b  = arb_gnt ? b1 : b0;

    assign active = (state == ISSUE) || (state == WAIT_DONE);
    assign tmo    = active && (cnt_q == CNT_MAX);
    // armed_q blocks a grant in the first cycle after reset release.
    assign grant  = (state == IDLE) && armed_q && arb_vld && alu.alu_rdy;
    assign bad_op = grant && is_illegal(sel_op);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (grant)
                    state_nx = bad_op ? RESP : ISSUE;
            end
            ISSUE: begin
                if (tmo)
                    state_nx = RESP;
                else if (!alu.alu_rdy)
                    state_nx = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (tmo || alu.alu_rdy)
                    state_nx = RESP;
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Aborts (illegal op, timeout) return a zero result.
    assign wr_res  = bad_op || tmo || ((state == WAIT_DONE) && alu.alu_rdy);
    assign tgt     = (state == IDLE) ? arb_gnt : gnt_q;
    assign res_nx  = ((state == WAIT_DONE) && !tmo) ? alu.alu_out : '0;
    assign cout_nx = (state == WAIT_DONE) && !tmo && alu.alu_cout;

    assign alu.alu_cs = (state == ISSUE) && !tmo;
    assign alu.alu_op = active ? op_q : '0;
    assign alu.alu_a  = active ? a_q : '0;
    assign alu.alu_b  = active ? b_q : '0;

    assign done0 = (state == RESP) && !gnt_q;
    assign done1 = (state == RESP) && gnt_q;
    assign busy  = state != IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            armed_q <= 1'b0;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            err     <= 1'b0;
        end else begin
            state   <= state_nx;
            armed_q <= 1'b1;
            if (grant) begin
                gnt_q <= arb_gnt;
                op_q  <= sel_op;
                a_q   <= sel_a;
                b_q   <= sel_b;
            end
            if (grant)
                cnt_q <= '0;
            else if (active)
                cnt_q <= cnt_q + CW'(1);
            if (bad_op || tmo)
                err <= 1'b1;
            if (state == RESP)
                last_q <= gnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res0  <= '0;
            res1  <= '0;
            cout0 <= 1'b0;
            cout1 <= 1'b0;
        end else if (wr_res) begin
            if (tgt) begin
                res1  <= res_nx;
                cout1 <= cout_nx;
            end else begin
                res0  <= res_nx;
                cout0 <= cout_nx;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a behavioural ALU.
// ALU model: latency/hang knobs; subtract carry is the 17th bit of a-b.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int TMO = TIMEOUT_DEF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1;
    logic [2:0]  op0, op1;
    logic [15:0] a0, b0, a1, b1;
    logic        done0, done1;
    logic [15:0] res0, res1;
    logic        cout0, cout1;
    logic        busy, err;

    int tests = 0;
    int fails = 0;
    int lat;
    logic hang;
    int bcnt;
    int d0_cnt = 0;
    int d1_cnt = 0;
    int cs_cnt = 0;

    always #5 clk = ~clk;

    alu_arbiter_if alu_bus ();

    alu_arbiter #(.TIMEOUT(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req0  (req0),
        .req1  (req1),
        .op0   (op0),
        .op1   (op1),
        .a0    (a0),
        .b0    (b0),
        .a1    (a1),
        .b1    (b1),
        .done0 (done0),
        .done1 (done1),
        .res0  (res0),
        .res1  (res1),
        .cout0 (cout0),
        .cout1 (cout1),
        .busy  (busy),
        .err   (err),
        .alu   (alu_bus)
    );

    function automatic logic [16:0] alu_f(input logic [2:0] op,
                                          input logic [15:0] a,
                                          input logic [15:0] b);
        logic [31:0] p;
        p = 32'(a) * 32'(b);
        case (op)
            OP_ADD:  return {1'b0, a} + {1'b0, b};
            OP_SUB:  return {1'b0, a} - {1'b0, b};
            OP_MUL:  return {|p[31:16], p[15:0]};
            3'd4:    return {1'b0, a & b};
            3'd5:    return {1'b0, a | b};
            3'd6:    return {1'b0, a ^ b};
            default: return {1'b0, ~a};
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_bus.alu_rdy  <= 1'b1;
            alu_bus.alu_out  <= '0;
            alu_bus.alu_cout <= 1'b0;
            bcnt             <= 0;
        end else if (alu_bus.alu_cs && alu_bus.alu_rdy) begin
            alu_bus.alu_rdy <= 1'b0;
            {alu_bus.alu_cout, alu_bus.alu_out} <=
                alu_f(alu_bus.alu_op, alu_bus.alu_a, alu_bus.alu_b);
            bcnt <= lat;
        end else if (!alu_bus.alu_rdy && !hang) begin
            if (bcnt == 0)
                alu_bus.alu_rdy <= 1'b1;
            else
                bcnt <= bcnt - 1;
        end
    end

    always @(posedge clk) begin
        if (done0)
            d0_cnt <= d0_cnt + 1;
        if (done1)
            d1_cnt <= d1_cnt + 1;
        if (alu_bus.alu_cs)
            cs_cnt <= cs_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int maxc, output int which,
                             output int cyc);
        which = -1;
        cyc = 0;
        for (int i = 1; i <= maxc; i++) begin
            @(negedge clk);
            if (done0 || done1) begin
                which = done1 ? 1 : 0;
                cyc = i;
                break;
            end
        end
    endtask

    task automatic rst_pulse();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int w, c, d0s, d1s, css, found;
        rst_n = 1'b0;
        req0 = 0; req1 = 0;
        op0 = 0; op1 = 0;
        a0 = 0; b0 = 0; a1 = 0; b1 = 0;
        lat = 1;
        hang = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_busy", busy, 0);
        chk("rst_done", {done1, done0}, 0);
        chk("rst_res0", res0, 0);
        chk("rst_res1", res1, 0);
        chk("rst_cout", {cout1, cout0}, 0);
        chk("rst_err", err, 0);
        chk("rst_cs", alu_bus.alu_cs, 0);
        chk("rst_bus", {alu_bus.alu_op, alu_bus.alu_a, alu_bus.alu_b}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // single add on requester 0
        d0s = d0_cnt; d1s = d1_cnt;
        op0 = OP_ADD; a0 = 16'h0003; b0 = 16'h0004; req0 = 1;
        @(negedge clk);
        chk("add_busy", busy, 1);
        chk("add_cs", alu_bus.alu_cs, 1);
        chk("add_alu_ab", {alu_bus.alu_a, alu_bus.alu_b}, 32'h0003_0004);
        wait_done(20, w, c);
        req0 = 0;
        chk("add_who", w, 0);
        chk("add_res0", res0, 16'h0007);
        chk("add_cout0", cout0, 0);
        repeat (3) @(negedge clk);
        chk("add_hold", res0, 16'h0007);
        chk("add_idle", busy, 0);
        chk("add_n_done0", d0_cnt - d0s, 1);
        chk("add_n_done1", d1_cnt - d1s, 0);

        // tie after reset, both held: 0, 1, 0
        rst_pulse();
        op0 = OP_ADD; a0 = 16'h0001; b0 = 16'h0002;
        op1 = 3'd4; a1 = 16'hF0F0; b1 = 16'hFF00;
        req0 = 1; req1 = 1;
        wait_done(20, w, c);
        chk("rr_first", w, 0);
        chk("rr_res0", res0, 16'h0003);
        wait_done(20, w, c);
        chk("rr_second", w, 1);
        chk("rr_res1", res1, 16'hF000);
        wait_done(20, w, c);
        req0 = 0; req1 = 0;
        chk("rr_third", w, 0);
        repeat (2) @(negedge clk);

        // subtract with borrow on requester 1
        op1 = OP_SUB; a1 = 16'h0000; b1 = 16'h0001; req1 = 1;
        wait_done(20, w, c);
        req1 = 0;
        chk("sub_who", w, 1);
        chk("sub_res1", res1, 16'hFFFF);
        chk("sub_cout1", cout1, 1);
        @(negedge clk);
        chk("sub_idle", busy, 0);

        // illegal opcode
        css = cs_cnt;
        op0 = OP_ILL; a0 = 16'h1234; b0 = 16'h5678; req0 = 1;
        wait_done(3, w, c);
        req0 = 0;
        chk("ill_who", w, 0);
        chk("ill_fast", (c >= 1 && c <= 3), 1);
        chk("ill_res0", res0, 0);
        chk("ill_cout0", cout0, 0);
        chk("ill_err", err, 1);
        repeat (2) @(negedge clk);
        chk("ill_no_cs", cs_cnt - css, 0);

        // ALU hangs: timeout abort, then normal service
        rst_pulse();
        chk("tmo_err_clr", err, 0);
        hang = 1'b1;
        op1 = OP_ADD; a1 = 16'h0005; b1 = 16'h0005; req1 = 1;
        wait_done(TMO + 10, w, c);
        req1 = 0;
        chk("tmo_who", w, 1);
        chk("tmo_cyc", c, TMO + 1);
        chk("tmo_res1", res1, 0);
        chk("tmo_cout1", cout1, 0);
        chk("tmo_err", err, 1);
        hang = 1'b0;
        @(negedge clk);
        chk("tmo_idle", busy, 0);
        op0 = OP_MUL; a0 = 16'h0012; b0 = 16'h0003; req0 = 1;
        wait_done(30, w, c);
        req0 = 0;
        chk("tmo_next_who", w, 0);
        chk("tmo_next_res0", res0, 16'h0036);
        @(negedge clk);

        // reset during WAIT_DONE
        lat = 10;
        op0 = OP_ADD; a0 = 16'h0001; b0 = 16'h0001; req0 = 1;
        found = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy && !alu_bus.alu_cs) begin
                found = 1;
                break;
            end
        end
        chk("ar_wait", found, 1);
        d0s = d0_cnt;
        #2 rst_n = 1'b0;
        #1;
        chk("ar_busy", busy, 0);
        chk("ar_done", {done1, done0}, 0);
        chk("ar_bus", {alu_bus.alu_cs, alu_bus.alu_op, alu_bus.alu_a, alu_bus.alu_b}, 0);
        chk("ar_res0", res0, 0);
        chk("ar_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        lat = 1;
        @(negedge clk);
        chk("ar_no_grant", busy, 0);
        chk("ar_no_done", d0_cnt - d0s, 0);
        wait_done(20, w, c);
        req0 = 0;
        chk("ar_next_who", w, 0);
        chk("ar_next_res0", res0, 16'h0002);
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 64, max cycles from ALU issue to ALU ready before abort.
REQ-002 clk  input  1  system clock, all state on rising edge.
REQ-003 rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 req0, req1  input  1 each  requester 0/1 operation request, held until matching done.
REQ-005 op0, op1  input  3 each  requester opcode (0 add, 1 sub, 2 mul, 4-7 logic, 3 illegal).
REQ-006 a0, b0, a1, b1  input  16 each  requester operands, stable while req high.
REQ-007 done0, done1  output  1 each  one-cycle completion pulse to requester.
REQ-008 res0, res1  output  16 each  result, valid in the done cycle and held until next done to that requester.
REQ-009 cout0, cout1  output  1 each  carry, same timing as res.
REQ-010 alu_cs  output  1  ALU chip select.
REQ-011 alu_op  output  3; alu_a, alu_b  output  16 each  ALU operation and operands.
REQ-012 alu_out  input  16; alu_cout  input  1; alu_rdy  input  1  ALU result, carry, ready.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 err  output  1  sticky: timeout or illegal opcode seen.

Function
REQ-015 FSM states: IDLE, ISSUE, WAIT_DONE, RESP.
REQ-016 IDLE: if any req high and alu_rdy high -> grant, latch op/a/b into internal registers, go ISSUE; else stay.
REQ-017 Grant: round-robin; single requester wins; both requesting -> one not granted last; after reset requester 0 wins first tie.
REQ-018 Illegal op (3) on grant: no ALU issue, go RESP with result 0, cout 0, err set.
REQ-019 ISSUE: alu_cs=1; stay until alu_rdy sampled low, then go WAIT_DONE with alu_cs=0.
REQ-020 WAIT_DONE: alu_cs=0; when alu_rdy sampled high, capture alu_out/alu_cout into granted requester's res/cout, go RESP.
REQ-021 RESP: pulse granted done for exactly one cycle, update last-grant, go IDLE.
REQ-022 alu_op/alu_a/alu_b driven from latched registers in ISSUE and WAIT_DONE; zero in IDLE and RESP.
REQ-023 Minimum latency req-high to done: 4 cycles plus ALU busy time.
REQ-024 Timeout counter: clears on entering ISSUE, increments each ISSUE/WAIT_DONE cycle; reaching TIMEOUT-1 -> alu_cs=0, err set, result 0, go RESP.
REQ-025 req sampled in RESP cycle ignored; a req still high in the next IDLE cycle is a new request.
REQ-026 Request changes by non-granted requester during service: no effect; it competes in next IDLE.
REQ-027 Deasserting granted req mid-operation: no effect; operation completes and done still pulses.

Reset
REQ-028 rst_n low: state IDLE, alu_cs 0, alu_op/a/b 0, done0/1 0, res0/1 0, cout0/1 0, busy 0, err 0, last-grant = requester 1, timeout counter 0.
REQ-029 Reset mid-operation aborts it without done pulse; no request granted in the first cycle after rst_n rises.

Structure
REQ-030 Shared package alu_pkg: opcode constants, FSM state encoding, TIMEOUT default.
REQ-031 One sub-module arb_rr2: two-way round-robin grant from req0/req1 and last-grant bit, purely combinational.

Verification
REQ-032 req0 op0=0 a0=16'h0003 b0=16'h0004 alone -> one done0, res0=16'h0007, cout0=0, done1 never.
REQ-033 req0 and req1 same cycle after reset, both held -> done0 first, then done1; third request pair -> requester 0 again only after requester 1 served.
REQ-034 req1 op1=1 a1=16'h0000 b1=16'h0001 -> res1=16'hFFFF, carry per ALU subtract convention, busy low after done1.
REQ-035 req0 op0=3 -> done0 within 3 cycles, res0=0, err=1, alu_cs never asserted.
REQ-036 ALU model holding alu_rdy low forever after cs -> done at TIMEOUT-cycle abort, res=0, err=1, FSM returns IDLE and serves next request.
REQ-037 rst_n pulsed low during WAIT_DONE -> all outputs zero asynchronously, no done pulse, next request serviced normally.
